// File: rtl/inst_fetch_buffer_if.sv
// Fetch-stage bus bundle: instruction memory port a, redirect input from EX,
// and the valid/ready handoff toward decode. The fetch unit uses "master",
// the surrounding pipeline/memory uses "slave".
interface inst_fetch_buffer_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              id_ready;
  logic              if_valid;
  logic [31:0]       if_instr;
  logic [31:0]       if_pc;

  modport master (
    output imem_addr, if_valid, if_instr, if_pc,
    input  imem_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc,
    output imem_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch stage. Issues word addresses to a memory with a fixed
// 2-cycle read latency, tags each request with its PC through a two-stage
// pipe, and parks returned words in a small FIFO that feeds decode.
// Issue is credit based: a new fetch goes out only when the FIFO is
// guaranteed room for it, so no returned word is ever dropped. A redirect
// throws away everything in flight and buffered and restarts at the target.
module inst_fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 14,
  parameter int          DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  inst_fetch_buffer_if.master bus
);

  localparam int          PTR_W     = $clog2(DEPTH);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [PTR_W+1:0] DEPTH_LIM = DEPTH[PTR_W+1:0];

  logic [31:0] pc;
  logic        s0_v, s1_v;
  logic [31:0] s0_pc, s1_pc;

  logic [31:0]      fifo_pc    [DEPTH];
  logic [31:0]      fifo_instr [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;

  logic [31:0]      redirect_target;
  logic [31:0]      fetch_pc;
  logic [PTR_W+1:0] in_flight;
  logic             issue;
  logic             head_valid;
  logic             push;
  logic             pop;

  // Fetch address selection, credit check and FIFO handshake decode
  always_comb begin
    redirect_target = bus.redirect_pc & ~32'h3;
    fetch_pc        = bus.redirect_valid ? redirect_target : pc;
    in_flight       = {1'b0, count}
                    + {{(PTR_W+1){1'b0}}, s0_v}
                    + {{(PTR_W+1){1'b0}}, s1_v};
    issue           = bus.redirect_valid || (in_flight < DEPTH_LIM);
    head_valid      = (count != '0);
    push            = s1_v && !bus.redirect_valid;
    pop             = head_valid && bus.id_ready && !bus.redirect_valid;
  end

  assign bus.imem_addr = fetch_pc[ADDR_W+1:2];
  assign bus.if_valid  = head_valid;
  assign bus.if_instr  = head_valid ? fifo_instr[rd_ptr] : NOP_INSTR;
  assign bus.if_pc     = head_valid ? fifo_pc[rd_ptr]    : 32'h0;

  // PC register and the two-stage request pipe that matches memory latency
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      s0_v  <= 1'b0;
      s1_v  <= 1'b0;
      s0_pc <= '0;
      s1_pc <= '0;
    end else begin
      s1_v  <= s0_v && !bus.redirect_valid;
      s1_pc <= s0_pc;
      s0_v  <= issue;
      s0_pc <= fetch_pc;
      if (issue) begin
        pc <= fetch_pc + 32'd4;
      end
    end
  end

  // Return FIFO: push tagged words as they arrive, pop on decode accept
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]    <= s1_pc;
        fifo_instr[wr_ptr] <= bus.imem_data;
        wr_ptr             <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Bench for inst_fetch_buffer. A 2-cycle-latency memory model answers fetches.
// The reference is a stream view of the stage: after a reset or redirect the
// head shows the start PC exactly 3 cycles later and stays valid from then on;
// each accepted head advances the expected PC by 4, and the instruction must
// be the memory word at that PC.
module tb_inst_fetch_buffer;

  localparam int          ADDR_W    = 14;
  localparam int          DEPTH     = 4;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  inst_fetch_buffer_if #(.ADDR_W(ADDR_W)) bus ();

  inst_fetch_buffer #(
    .RESET_PC(RESET_PC),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rd1, rd2;

  // Memory port a: address sampled every edge, data two cycles later
  always @(posedge clk) begin
    rd1 <= mem[bus.imem_addr];
    rd2 <= rd1;
  end
  assign bus.imem_data = rd2;

  int          total = 0;
  int          bad   = 0;
  int          age   = 0;
  logic [31:0] exp_pc;
  bit          exp_valid;
  bit          model_live = 0;
  bit          addr_chk   = 0;
  logic [31:0] addr_chk_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] p);
    return mem[p[ADDR_W+1:2]];
  endfunction

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Compare the current cycle's outputs against the stream model
  task automatic checkOutput();
    logic [31:0] rp;
    exp_valid = (age >= 3);
    check1("if_valid", {31'b0, bus.if_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      check1("if_pc", bus.if_pc, exp_pc);
      check1("if_instr", bus.if_instr, mem_word(exp_pc));
    end else begin
      check1("if_pc_idle", bus.if_pc, 32'h0);
      check1("if_instr_nop", bus.if_instr, NOP_INSTR);
    end
    if (!rst && bus.redirect_valid) begin
      rp = bus.redirect_pc;
      check1("imem_addr_redirect", {{(32-ADDR_W){1'b0}}, bus.imem_addr},
             {{(32-ADDR_W){1'b0}}, rp[ADDR_W+1:2]});
    end else if (!rst && addr_chk) begin
      check1("imem_addr_next", {{(32-ADDR_W){1'b0}}, bus.imem_addr},
             {{(32-ADDR_W){1'b0}}, addr_chk_pc[ADDR_W+1:2]});
    end
  endtask

  // One clock cycle: drive inputs away from the edge, check, advance the model
  task automatic applyStimulus(input logic r, input logic rv,
                               input logic [31:0] rp, input logic rdy);
    @(negedge clk);
    rst                = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    bus.id_ready       = rdy;
    #1;
    if (model_live) checkOutput();
    else exp_valid = 1'b0;
    addr_chk = 1'b0;
    if (r) begin
      age         = 0;
      exp_pc      = RESET_PC;
      addr_chk    = 1'b1;
      addr_chk_pc = RESET_PC;
      model_live  = 1'b1;
    end else if (rv) begin
      age         = 1;
      exp_pc      = rp & ~32'h3;
      addr_chk    = 1'b1;
      addr_chk_pc = (rp & ~32'h3) + 32'd4;
    end else begin
      if (exp_valid && rdy) exp_pc = exp_pc + 32'd4;
      if (age < 3) age++;
    end
  endtask

  task automatic runCycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, rdy);
  endtask

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = 32'h100 + i;
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b0;

    // Reset, then a continuous stream
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    runCycles(12, 1'b1);

    // Decode stall fills the FIFO, then drains without loss or duplication
    runCycles(10, 1'b0);
    runCycles(8, 1'b1);

    // Redirect in a steady stream
    applyStimulus(1'b0, 1'b1, 32'h0000_0040, 1'b1);
    runCycles(8, 1'b1);

    // Redirect with a full FIFO, target held until decode accepts
    runCycles(8, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0080, 1'b0);
    runCycles(6, 1'b0);
    runCycles(6, 1'b1);

    // Unaligned target has its low bits forced to zero
    applyStimulus(1'b0, 1'b1, 32'h0000_0046, 1'b1);
    runCycles(6, 1'b1);

    // Mid-stream reset discards everything
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    runCycles(8, 1'b1);

    // PC wraps from the top of the address space back to zero
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    runCycles(6, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF4, 1'b1);
    runCycles(8, 1'b1);

    // Back-to-back redirects: the second one wins
    applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    runCycles(8, 1'b1);

    // Random decode back-pressure, redirects and occasional resets
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 11) == 0),
                    $urandom(),
                    ($urandom_range(0, 9) < 7));
    end
    runCycles(6, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
